led_pio_blink: RTL and testbench
================================

# led_pio_blink

Parametrised Avalon-MM output PIO for the wallet status LEDs, and the successor to the fixed 8-bit LED output port. It provides a WIDTH-bit output register with atomic set and clear aliases, plus a per-channel hardware blink mode. Blinking is driven by a programmable prescaler, so the Nios firmware no longer has to toggle LEDs in software. It sits on the Nios data master as a zero-wait-state slave, and out_port drives the board LED pins.

## Interface
- WIDTH, 8: number of output channels (1..32).
- PRESCALE_W, 24: width of the PERIOD register and the prescaler counter (1..32).
- RESET_VALUE, 0: reset value of DATA (WIDTH bits).
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data; bits above the register width are ignored.
- readdata  out  32  read data; combinational, zero-extended.
- out_port  out  WIDTH  LED drive.

## Operation
- Register map (word address):
  - 0 DATA: read/write; holds the base output bits.
  - 1 OUTSET: write sets DATA bits where writedata is 1 (DATA |= wd); read returns DATA.
  - 2 OUTCLR: write clears DATA bits where writedata is 1 (DATA &= ~wd); read returns DATA.
  - 3 BLINK_EN: read/write per-channel blink mask.
  - 4 PERIOD: read/write, PRESCALE_W bits.
  - 5 STATUS: read-only; bit0 = phase, bit1 = (PERIOD != 0), other bits 0.
  - 6, 7: reads return 0; writes are ignored.
- A write occurs when chipselect=1 and write_n=0 at a rising clk edge.
- Reads have no side effects.
- out_port[i] = DATA[i] & (~BLINK_EN[i] | phase). Computed from registered state only; no combinational path from the bus.
- Prescaler (counter cnt, PRESCALE_W bits; flag phase):
  - PERIOD = 0: cnt held at 0, phase held at 1. Blink-enabled channels show steady DATA.
  - PERIOD = P > 0, cnt == 0: cnt <= P and phase <= ~phase.
  - PERIOD = P > 0, cnt != 0: cnt <= cnt - 1.
  - Result: phase toggles every P+1 clocks, so blink period is 2(P+1) clocks at 50% duty.
- A write to PERIOD loads PERIOD <= wd, cnt <= wd and phase <= 1 on the same edge. This restarts the blink cleanly.
- A write to PERIOD has priority over a terminal-count toggle in the same cycle.
- Writes to DATA, OUTSET, OUTCLR and BLINK_EN do not disturb cnt or phase.
- Reset values:
  - DATA = RESET_VALUE; BLINK_EN = 0; PERIOD = 0; cnt = 0; phase = 1.
  - out_port = RESET_VALUE.
  - readdata follows address combinationally; with address 0 it reads RESET_VALUE.
- Reset is asserted asynchronously and released synchronously by the system reset controller. Mid-operation reset returns all state to the reset values immediately.

## Timing
- Zero wait states; read latency 0. readdata is valid in the same cycle as address/chipselect.
- A write at edge k is visible on readdata and out_port after edge k (one-clock latency).
- After a PERIOD write at edge k with P > 0:
  - phase stays 1 through edge k+P.
  - First toggle to 0 occurs at edge k+P+1.
  - Next toggle to 1 occurs at edge k+2P+2.
- PERIOD = 1 gives the fastest blink: 2 clocks on, 2 clocks off.
- Arithmetic: cnt decrement has no wrap-around because it is reloaded at 0. All writedata fields are truncated to register width.

## Test plan
- Reset with RESET_VALUE=8'hA5 → out_port=8'hA5, readdata at address 3/4=0, STATUS=32'h1.
- Write DATA=8'h0F, OUTSET=8'hF0, OUTCLR=8'h81 → out_port sequence 0F, FF, 7E, each one clock after its write; reads at addresses 0, 1 and 2 return 8'h7E.
- DATA=8'hFF, BLINK_EN=8'h03, PERIOD=3 → out_port[1:0] is 11 for 4 clocks then 00 for 4 clocks, repeating; out_port[7:2] steady 1; STATUS bit0 tracks phase.
- While blinking with PERIOD=3, write PERIOD=0 during the low phase → phase=1 on the next clock and out_port=8'hFF steady; STATUS=32'h1.
- Write PERIOD=5 in the same cycle as a terminal-count toggle → cnt=5, phase=1, and next toggle exactly 6 clocks later; write to address 6 → no state change, read of address 7 returns 0.
- Assert reset_n low mid-blink, asynchronously between clock edges → out_port=RESET_VALUE immediately; BLINK_EN, PERIOD and cnt are 0 and phase is 1 after release.

Source files
------------

// File: rtl/led_pio_blink_if.sv
// Avalon-MM slave bus bundle for the LED output PIO.
// The master drives the request side; the slave returns combinational read data.
interface led_pio_blink_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/led_pio_blink.sv
// WIDTH-bit LED output PIO with set/clear aliases and a prescaled per-channel blink.
// Zero-wait-state Avalon-MM slave; out_port is derived from registered state only.
module led_pio_blink #(
  parameter int unsigned           WIDTH       = 8,
  parameter int unsigned           PRESCALE_W  = 24,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  led_pio_blink_if.slave       bus,
  output logic [WIDTH-1:0]     out_port
);

  typedef enum logic [2:0] {
    ADDR_DATA     = 3'd0,
    ADDR_OUTSET   = 3'd1,
    ADDR_OUTCLR   = 3'd2,
    ADDR_BLINK_EN = 3'd3,
    ADDR_PERIOD   = 3'd4,
    ADDR_STATUS   = 3'd5
  } reg_addr_e;

  logic [WIDTH-1:0]      data_q;
  logic [WIDTH-1:0]      blink_en_q;
  logic [PRESCALE_W-1:0] period_q;
  logic [PRESCALE_W-1:0] cnt_q;
  logic                  phase_q;

  logic                  wr_en;
  logic [WIDTH-1:0]      wd_chan;
  logic [PRESCALE_W-1:0] wd_period;
  logic                  period_wr;

  // Upper writedata bits beyond the register widths are intentionally dropped.
  logic unused_writedata;
  assign unused_writedata = ^bus.writedata;

  assign wr_en     = bus.chipselect && !bus.write_n;
  assign wd_chan   = bus.writedata[WIDTH-1:0];
  assign wd_period = bus.writedata[PRESCALE_W-1:0];
  assign period_wr = wr_en && (bus.address == ADDR_PERIOD);

  // Output and blink-mask registers; writes here never touch the prescaler.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= RESET_VALUE;
      blink_en_q <= '0;
    end else if (wr_en) begin
      case (bus.address)
        ADDR_DATA:     data_q     <= wd_chan;
        ADDR_OUTSET:   data_q     <= data_q | wd_chan;
        ADDR_OUTCLR:   data_q     <= data_q & ~wd_chan;
        ADDR_BLINK_EN: blink_en_q <= wd_chan;
        default:       ;
      endcase
    end
  end

  // Prescaler: a PERIOD write restarts the blink with phase high and wins over a
  // same-cycle terminal count; cnt reloads at zero so it never wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_q <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b1;
    end else if (period_wr) begin
      period_q <= wd_period;
      cnt_q    <= wd_period;
      phase_q  <= 1'b1;
    end else if (period_q == '0) begin
      cnt_q    <= '0;
      phase_q  <= 1'b1;
    end else if (cnt_q == '0) begin
      cnt_q    <= period_q;
      phase_q  <= ~phase_q;
    end else begin
      cnt_q    <= cnt_q - 1'b1;
    end
  end

  assign out_port = data_q & (~blink_en_q | {WIDTH{phase_q}});

  // NOTE: readdata gets a default first so no address leaves it unassigned (no latch).
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DATA,
      ADDR_OUTSET,
      ADDR_OUTCLR:   bus.readdata = 32'(data_q);
      ADDR_BLINK_EN: bus.readdata = 32'(blink_en_q);
      ADDR_PERIOD:   bus.readdata = 32'(period_q);
      ADDR_STATUS:   bus.readdata = {30'd0, (period_q != '0), phase_q};
      default:       bus.readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_led_pio_blink.sv
// Bench for led_pio_blink: a time-based register/blink model checked every cycle,
// plus directed vectors with hand-computed values.
module tb_led_pio_blink;
  localparam int unsigned      WIDTH = 8;
  localparam int unsigned      PW    = 24;
  localparam logic [WIDTH-1:0] RV    = 8'hA5;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [WIDTH-1:0] out_port;

  led_pio_blink_if bus_if ();

  led_pio_blink #(.WIDTH(WIDTH), .PRESCALE_W(PW), .RESET_VALUE(RV)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus_if),
    .out_port (out_port)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase derived from the number of edges since the last PERIOD write.
  logic [WIDTH-1:0] m_data   = RV;
  logic [WIDTH-1:0] m_blink  = '0;
  logic [PW-1:0]    m_period = '0;
  int               m_edges  = 0;

  function automatic logic m_phase();
    if (m_period == '0) return 1'b1;
    return ((m_edges / (int'(m_period) + 1)) % 2) == 0;
  endfunction

  function automatic logic [WIDTH-1:0] m_out();
    return m_data & (~m_blink | {WIDTH{m_phase()}});
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0, 3'd1, 3'd2: return 32'(m_data);
      3'd3:             return 32'(m_blink);
      3'd4:             return 32'(m_period);
      3'd5:             return {30'd0, (m_period != '0), m_phase()};
      default:          return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data = RV; m_blink = '0; m_period = '0; m_edges = 0;
    end else begin
      m_edges++;
      if (bus_if.chipselect && !bus_if.write_n) begin
        case (bus_if.address)
          3'd0: m_data = bus_if.writedata[WIDTH-1:0];
          3'd1: m_data = m_data | bus_if.writedata[WIDTH-1:0];
          3'd2: m_data = m_data & ~bus_if.writedata[WIDTH-1:0];
          3'd3: m_blink = bus_if.writedata[WIDTH-1:0];
          3'd4: begin m_period = bus_if.writedata[PW-1:0]; m_edges = 0; end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_out", 32'(out_port), 32'(m_out()));
    check("cyc_rd", bus_if.readdata, m_read(bus_if.address));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus_if.address = a; bus_if.writedata = d;
    bus_if.chipselect = 1'b1; bus_if.write_n = 1'b0;
    @(posedge clk); #1;
    bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1;
  endtask

  task automatic read_check(input string name, input logic [2:0] a, input logic [31:0] exp);
    bus_if.address = a; bus_if.chipselect = 1'b1; bus_if.write_n = 1'b1;
    #1;
    check(name, bus_if.readdata, exp);
    bus_if.chipselect = 1'b0; bus_if.address = 3'd0;
  endtask

  initial begin
    bus_if.address = 3'd0; bus_if.chipselect = 1'b0;
    bus_if.write_n = 1'b1; bus_if.writedata = '0;

    // Reset state
    tick(2);
    reset_n = 1'b1;
    tick(1);
    check("rst_out", 32'(out_port), 32'h0000_00A5);
    read_check("rst_data", 3'd0, 32'h0000_00A5);
    read_check("rst_blink", 3'd3, 32'h0);
    read_check("rst_period", 3'd4, 32'h0);
    read_check("rst_status", 3'd5, 32'h1);

    // DATA / OUTSET / OUTCLR
    bus_write(3'd0, 32'hFFFF_FF0F);
    check("wr_data", 32'(out_port), 32'h0F);
    bus_write(3'd1, 32'h0000_00F0);
    check("wr_set", 32'(out_port), 32'hFF);
    bus_write(3'd2, 32'h0000_0081);
    check("wr_clr", 32'(out_port), 32'h7E);
    read_check("rd_a0", 3'd0, 32'h7E);
    read_check("rd_a1", 3'd1, 32'h7E);
    read_check("rd_a2", 3'd2, 32'h7E);

    // Blink with PERIOD=3: 4 clocks high, 4 low on channels 1:0
    bus_write(3'd0, 32'hFF);
    bus_write(3'd3, 32'h03);
    bus_write(3'd4, 32'd3);
    for (int i = 0; i < 8; i++) begin
      check("blink3_out", 32'(out_port), (i < 4) ? 32'hFF : 32'hFC);
      read_check("blink3_status", 3'd5, (i < 4) ? 32'h3 : 32'h2);
      tick(1);
    end
    check("blink3_wrap", 32'(out_port), 32'hFF);
    tick(4);
    check("blink3_low", 32'(out_port), 32'hFC);

    // PERIOD=0 during the low phase forces steady output
    bus_write(3'd4, 32'd0);
    check("p0_out", 32'(out_port), 32'hFF);
    read_check("p0_status", 3'd5, 32'h1);
    tick(5);
    check("p0_steady", 32'(out_port), 32'hFF);

    // PERIOD=5 written on the edge where PERIOD=2 would toggle
    bus_write(3'd4, 32'd2);
    tick(2);
    check("pre_toggle", 32'(out_port), 32'hFF);
    bus_write(3'd4, 32'hFF00_0005);
    for (int i = 0; i < 7; i++) begin
      check("p5_out", 32'(out_port), (i < 6) ? 32'hFF : 32'hFC);
      if (i < 6) tick(1);
    end
    read_check("p5_status", 3'd5, 32'h2);

    // Unmapped addresses
    bus_write(3'd6, 32'hFFFF_FFFF);
    read_check("a6_data", 3'd0, 32'hFF);
    read_check("a6_blink", 3'd3, 32'h03);
    read_check("a6_period", 3'd4, 32'h5);
    read_check("a6_read", 3'd6, 32'h0);
    read_check("a7_read", 3'd7, 32'h0);

    // Asynchronous reset mid-blink, between clock edges
    tick(3);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_out", 32'(out_port), 32'hA5);
    tick(2);
    reset_n = 1'b1;
    tick(1);
    read_check("arst_blink", 3'd3, 32'h0);
    read_check("arst_period", 3'd4, 32'h0);
    read_check("arst_status", 3'd5, 32'h1);
    tick(3);
    check("arst_steady", 32'(out_port), 32'hA5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
